ppu_vram_arbiter: RTL and testbench

PPU_VRAM_ARBITER -- requirements
Module: ppu_vram_arbiter

---
 rtl/ppu_vram_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_ppu_vram_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_arbiter.sv
// ppu_vram_arbiter: shares the PPU VRAM bus between the renderer and CPU $2007 port.
// Every access is two cycles, ISSUE then DATA. The renderer wins ties.
// The pattern ROM (CHR) range is read-only. Palette space is never written and reads back 0x00.
// Optional starvation guard: define PPU_ARB_STARVE_GUARD_EN to give the CPU one grant
// after STARVE_LIMIT consecutive renderer grants made while the CPU was waiting.
// Without the macro, priority is strictly renderer-first and there is no counter.
module ppu_vram_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rnd_req,
  input  logic [15:0] rnd_addr,
  output logic [7:0]  rnd_data,
  output logic        rnd_valid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        mirror_v,
  output logic [10:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic [12:0] chr_addr,
  input  logic [7:0]  chr_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DATA} state_t;
  typedef enum logic [1:0] {R_CHR, R_NT, R_PAL} region_t;

  // Decode uses only the low 14 bits; 0x3000-0x3EFF fall into the nametable range.
  function automatic region_t decode(input logic [13:0] a);
    region_t r;
    if (!a[13])                r = R_CHR;
    else if (a[13:8] == 6'h3F) r = R_PAL;
    else                       r = R_NT;
    return r;
  endfunction

  state_t        state_q, state_d;
  region_t       region_q, region_d;
  logic          owner_cpu_q, owner_cpu_d;
  logic          we_q, we_d;
  logic [10:0]   vram_addr_q, vram_addr_d;
  logic [12:0]   chr_addr_q, chr_addr_d;
  logic          vram_we_q, vram_we_d;
  logic [7:0]    vram_wdata_q, vram_wdata_d;
  logic          rnd_valid_q, rnd_valid_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [7:0]    rnd_data_q, rnd_data_d;
  logic [7:0]    cpu_rdata_q, cpu_rdata_d;

  logic          any_req;
  logic          arb_start;
  logic          grant_cpu;
  logic [13:0]   win_addr;
  region_t       win_region;
  logic          win_we;
  logic [10:0]   win_vaddr;
  logic [7:0]    rdata_sel;

  // The top two address bits are discarded by design.
  logic [3:0]    unused_addr_hi;
  assign unused_addr_hi = {rnd_addr[15:14], cpu_addr[15:14]};

  assign any_req   = rnd_req | cpu_req;
  assign arb_start = ((state_q == S_IDLE) || (state_q == S_DATA)) && any_req;

`ifdef PPU_ARB_STARVE_GUARD_EN
  localparam int CW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          force_cpu;

  assign force_cpu = cpu_req && (starve_cnt_q >= LIMIT_C);
  assign grant_cpu = cpu_req && (!rnd_req || force_cpu);

  // Count renderer grants that jumped ahead of a waiting CPU; any CPU grant or idle CPU clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!cpu_req) begin
      starve_cnt_d = '0;
    end else if (arb_start) begin
      if (grant_cpu)                    starve_cnt_d = '0;
      else if (starve_cnt_q != LIMIT_C) starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (reset) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end
`else
  logic [31:0] unused_limit;
  assign unused_limit = STARVE_LIMIT;
  assign grant_cpu    = cpu_req && !rnd_req;
`endif

  assign win_addr   = grant_cpu ? cpu_addr[13:0] : rnd_addr[13:0];
  assign win_region = decode(win_addr);
  assign win_we     = grant_cpu & cpu_we;
  assign win_vaddr  = mirror_v ? {win_addr[10], win_addr[9:0]} : {win_addr[11], win_addr[9:0]};

  // Read data for the access in DATA; palette space reads as zero.
  always_comb begin
    rdata_sel = 8'h00;
    case (region_q)
      R_CHR:   rdata_sel = chr_rdata;
      R_NT:    rdata_sel = vram_rdata;
      default: rdata_sel = 8'h00;
    endcase
  end

  // Strobes are suppressed while reset is high so an abandoned access never completes.
  assign rnd_valid  = rnd_valid_q & ~reset;
  assign cpu_ack    = cpu_ack_q & ~reset;
  assign rnd_data   = rnd_valid ? rdata_sel : rnd_data_q;
  assign cpu_rdata  = (cpu_ack && !we_q) ? rdata_sel : cpu_rdata_q;
  assign vram_addr  = vram_addr_q;
  assign chr_addr   = chr_addr_q;
  assign vram_we    = vram_we_q;
  assign vram_wdata = vram_wdata_q;

  // Next-state, winner latch and strobe generation.
  always_comb begin
    state_d      = state_q;
    region_d     = region_q;
    owner_cpu_d  = owner_cpu_q;
    we_d         = we_q;
    vram_addr_d  = vram_addr_q;
    chr_addr_d   = chr_addr_q;
    vram_we_d    = 1'b0;
    vram_wdata_d = vram_wdata_q;
    rnd_valid_d  = 1'b0;
    cpu_ack_d    = 1'b0;
    rnd_data_d   = rnd_data;
    cpu_rdata_d  = cpu_rdata;

    case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: begin
        state_d     = S_DATA;
        rnd_valid_d = !owner_cpu_q;
        cpu_ack_d   = owner_cpu_q;
      end
      S_DATA:  state_d = any_req ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (arb_start) begin
      owner_cpu_d = grant_cpu;
      region_d    = win_region;
      we_d        = win_we;
      if (win_region == R_NT)  vram_addr_d = win_vaddr;
      if (win_region == R_CHR) chr_addr_d  = win_addr[12:0];
      if (win_we)              vram_wdata_d = cpu_wdata;
      vram_we_d = win_we && (win_region == R_NT);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      region_q     <= R_CHR;
      owner_cpu_q  <= 1'b0;
      we_q         <= 1'b0;
      vram_addr_q  <= '0;
      chr_addr_q   <= '0;
      vram_we_q    <= 1'b0;
      vram_wdata_q <= '0;
      rnd_valid_q  <= 1'b0;
      cpu_ack_q    <= 1'b0;
      rnd_data_q   <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      region_q     <= region_d;
      owner_cpu_q  <= owner_cpu_d;
      we_q         <= we_d;
      vram_addr_q  <= vram_addr_d;
      chr_addr_q   <= chr_addr_d;
      vram_we_q    <= vram_we_d;
      vram_wdata_q <= vram_wdata_d;
      rnd_valid_q  <= rnd_valid_d;
      cpu_ack_q    <= cpu_ack_d;
      rnd_data_q   <= rnd_data_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Directed bench for ppu_vram_arbiter. The nametable RAM and CHR ROM are modelled here.
// The CHR ROM returns chr_addr[7:0] ^ 0xA5 one cycle after the address.
module tb_ppu_vram_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        rnd_req;
  logic [15:0] rnd_addr;
  logic [7:0]  rnd_data;
  logic        rnd_valid;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        mirror_v;
  logic [10:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic [12:0] chr_addr;
  logic [7:0]  chr_rdata;

  int tests = 0;
  int fails = 0;
  int we_pulses = 0;
  logic [7:0] vram_mem [2048];

  ppu_vram_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .rnd_req(rnd_req), .rnd_addr(rnd_addr), .rnd_data(rnd_data), .rnd_valid(rnd_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mirror_v(mirror_v), .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata), .chr_addr(chr_addr), .chr_rdata(chr_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (vram_we) vram_mem[vram_addr] <= vram_wdata;
    vram_rdata <= vram_mem[vram_addr];
    chr_rdata  <= chr_addr[7:0] ^ 8'hA5;
  end

  always @(negedge clk) begin
    if (vram_we) we_pulses++;
    if (!reset) begin
      tests++;
      assert (!(rnd_valid && cpu_ack)) else begin
        fails++;
        $error("FAIL both_strobes: observed rnd_valid=%0b cpu_ack=%0b expected not both", rnd_valid, cpu_ack);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One CPU access; lat is cycles from request to ack, or 99 if no ack within the budget.
  task automatic cpu_op(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                        output logic [7:0] rd, output int lat);
    int n;
    logic seen;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    n = 0; seen = 1'b0; rd = 8'hxx;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (cpu_ack) begin seen = 1'b1; rd = cpu_rdata; end
    end
    cpu_req = 1'b0;
    lat = seen ? n : 99;
  endtask

  initial begin
    logic [7:0] rd;
    int lat, p, cyc, rcnt, first_r, last_r, cpu_cyc;
    logic cpu_seen;

    reset = 1'b1; rnd_req = 1'b0; rnd_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; mirror_v = 1'b0;
    repeat (2) tick();
    chk("rst_rnd_valid", rnd_valid, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_vram_we", vram_we, 0);
    chk("rst_vram_addr", vram_addr, 0);
    chk("rst_chr_addr", chr_addr, 0);
    chk("rst_rnd_data", rnd_data, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_vram_wdata", vram_wdata, 0);
    reset = 1'b0;
    tick();

    // Seed nametable 0x041 with 0x5A through the CPU port.
    cpu_op(1'b1, 16'h2041, 8'h5A, rd, lat);
    chk("wr_2041_lat", lat, 2);
    chk("wr_2041_pulses", we_pulses, 1);
    chk("wr_keeps_cpu_rdata", cpu_rdata, 8'h00);
    tick();

    // Renderer read of 0x2041 with horizontal mirroring.
    rnd_addr = 16'h2041; rnd_req = 1'b1;
    tick();
    chk("r22_issue_vaddr", vram_addr, 11'h041);
    chk("r22_issue_no_valid", rnd_valid, 0);
    tick();
    chk("r22_valid", rnd_valid, 1);
    chk("r22_data", rnd_data, 8'h5A);
    rnd_req = 1'b0;
    tick();
    chk("r22_valid_one_cycle", rnd_valid, 0);
    chk("r22_data_hold", rnd_data, 8'h5A);

    // Vertical mirroring write: 0x2C05 has A10 set, so it lands at 0x405.
    mirror_v = 1'b1;
    cpu_we = 1'b1; cpu_addr = 16'h2C05; cpu_wdata = 8'h77; cpu_req = 1'b1;
    tick();
    chk("r23_issue_vaddr", vram_addr, 11'h405);
    chk("r23_issue_we", vram_we, 1);
    chk("r23_wdata", vram_wdata, 8'h77);
    tick();
    chk("r23_data_we_low", vram_we, 0);
    chk("r23_ack", cpu_ack, 1);
    cpu_req = 1'b0;
    tick();
    chk("r23_ack_one_cycle", cpu_ack, 0);
    cpu_op(1'b0, 16'h2405, 8'h00, rd, lat);
    chk("r23_rd_2405", rd, 8'h77);
    chk("r23_rd_lat", lat, 2);
    cpu_op(1'b0, 16'h3405, 8'h00, rd, lat);
    chk("alias_3405", rd, 8'h77);
    tick();

    // Contention from IDLE: renderer (CHR 0x0010) first, CPU (0x2041) second.
    mirror_v = 1'b0;
    rnd_addr = 16'h0010; rnd_req = 1'b1;
    cpu_we = 1'b0; cpu_addr = 16'h2041; cpu_req = 1'b1;
    tick();
    chk("r24_c1_chr_addr", chr_addr, 13'h0010);
    tick();
    chk("r24_c2_rnd_valid", rnd_valid, 1);
    chk("r24_c2_cpu_ack", cpu_ack, 0);
    chk("r24_c2_rnd_data", rnd_data, 8'hB5);
    rnd_req = 1'b0;
    tick();
    chk("r24_c3_cpu_ack", cpu_ack, 0);
    chk("r24_c3_vaddr", vram_addr, 11'h041);
    tick();
    chk("r24_c4_cpu_ack", cpu_ack, 1);
    chk("r24_c4_cpu_rdata", cpu_rdata, 8'h5A);
    cpu_req = 1'b0;
    tick();

    // Boundaries.
    cpu_op(1'b0, 16'h2C05, 8'h00, rd, lat);
    chk("h_rd_2c05", rd, 8'h77);
    chk("h_vaddr_405", vram_addr, 11'h405);
    cpu_op(1'b0, 16'h3F10, 8'h00, rd, lat);
    chk("pal_rd_3f10", rd, 8'h00);
    chk("pal_rd_lat", lat, 2);
    cpu_op(1'b0, 16'h7041, 8'h00, rd, lat);
    chk("mask_7041_vaddr", vram_addr, 11'h041);
    chk("mask_7041_data", rd, 8'h5A);
    p = we_pulses;
    cpu_op(1'b1, 16'h0005, 8'h99, rd, lat);
    chk("chr_wr_lat", lat, 2);
    chk("chr_wr_no_we", we_pulses, p);
    cpu_op(1'b1, 16'h3F05, 8'h11, rd, lat);
    chk("pal_wr_lat", lat, 2);
    chk("pal_wr_no_we", we_pulses, p);
    cpu_op(1'b0, 16'h3F05, 8'h00, rd, lat);
    chk("pal_rd_3f05", rd, 8'h00);
    cpu_op(1'b0, 16'h0005, 8'h00, rd, lat);
    chk("chr_rd_0005", rd, 8'hA0);
    tick();

    // Starvation: renderer held high on CHR 0x0010, CPU waiting on 0x2041.
    rnd_addr = 16'h0010; rnd_req = 1'b1;
    cpu_we = 1'b0; cpu_addr = 16'h2041; cpu_req = 1'b1;
    cyc = 0; rcnt = 0; first_r = 0; last_r = 0; cpu_cyc = 0; cpu_seen = 1'b0;
`ifdef PPU_ARB_STARVE_GUARD_EN
    while (!cpu_seen && cyc < 40) begin
      tick(); cyc++;
      if (rnd_valid) begin rcnt++; if (first_r == 0) first_r = cyc; last_r = cyc; end
      if (cpu_ack) begin cpu_seen = 1'b1; cpu_cyc = cyc; end
    end
    rnd_req = 1'b0; cpu_req = 1'b0;
    chk("starve_rnd_strobes", rcnt, 8);
    chk("starve_first_r", first_r, 2);
    chk("starve_last_r", last_r, 16);
    chk("starve_cpu_cycle", cpu_cyc, 18);
    chk("starve_cpu_rdata", cpu_rdata, 8'h5A);
`else
    while (cyc < 30) begin
      tick(); cyc++;
      if (rnd_valid) begin rcnt++; if (first_r == 0) first_r = cyc; last_r = cyc; end
      if (cpu_ack) cpu_seen = 1'b1;
    end
    chk("strict_no_cpu_ack", cpu_seen, 0);
    chk("strict_rnd_strobes", rcnt, 15);
    chk("strict_first_r", first_r, 2);
    chk("strict_last_r", last_r, 30);
    rnd_req = 1'b0;
    cyc = 0;
    while (!cpu_seen && cyc < 10) begin
      tick(); cyc++;
      if (cpu_ack) begin cpu_seen = 1'b1; cpu_cyc = cyc; end
    end
    cpu_req = 1'b0;
    chk("strict_cpu_after_drop", cpu_cyc, 2);
    chk("strict_cpu_rdata", cpu_rdata, 8'h5A);
`endif
    tick();

    // Reset asserted while the renderer access is in DATA.
    rnd_addr = 16'h2041; rnd_req = 1'b1;
    tick();
    @(posedge clk);
    #1;
    reset = 1'b1; rnd_req = 1'b0;
    #1;
    chk("rstdata_no_strobe_now", rnd_valid, 0);
    tick();
    chk("rstdata_no_strobe_neg", rnd_valid, 0);
    tick();
    chk("rstdata_rnd_valid", rnd_valid, 0);
    chk("rstdata_cpu_ack", cpu_ack, 0);
    chk("rstdata_vram_we", vram_we, 0);
    chk("rstdata_rnd_data", rnd_data, 0);
    chk("rstdata_cpu_rdata", cpu_rdata, 0);
    chk("rstdata_vram_addr", vram_addr, 0);
    chk("rstdata_chr_addr", chr_addr, 0);
    chk("rstdata_vram_wdata", vram_wdata, 0);
    reset = 1'b0;
    tick();
    chk("rstdata_no_late_strobe", rnd_valid, 0);
    cpu_op(1'b0, 16'h2041, 8'h00, rd, lat);
    chk("post_rst_rd", rd, 8'h5A);
    chk("post_rst_lat", lat, 2);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
